uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receiver peripheral for the servant SoC: the receive-side counterpart of the o_txd transmit path.
- Lets host/debug tooling send commands and data bytes into the chip, e.g. SNN control and parameter tweaks, without reflashing.
- Deserialises 8N1 frames from an asynchronous rx pin into a small byte FIFO.
- Presents the FIFO to the CPU-side bus bridge as a valid/ready byte stream, with framing and overrun error flags.

Parameters:
- CLK_FREQ, 12_000_000: wb_clk frequency in Hz.
- BAUD, 115200: line rate; CPB = CLK_FREQ/BAUD (integer, truncated), HALF = CPB/2.
- FIFO_DEPTH, 4: byte entries, power of two, >= 2.

Ports:
- wb_clk  in  1  system clock.
- wb_rst  in  1  synchronous, active-high reset.
- i_rxd  in  1  asynchronous serial input, idle high.
- o_data  out  8  byte at FIFO head.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer accepts o_data; pop on o_valid & i_ready.
- o_frame_err  out  1  sticky: stop bit sampled low (or parity mismatch, see option).
- o_overrun  out  1  sticky: byte dropped because the FIFO was full.
- i_err_clr  in  1  one-cycle pulse clears both sticky flags.
- o_busy  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset state:
  - All outputs low: o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
  - 2-flop synchroniser flops reset to 1, so no false start after reset.
  - FIFO emptied, FSM in IDLE, baud counter 0.
- Reset mid-frame aborts the frame; the partial byte is discarded.
- All sampling uses synchronised rx (rx_s), which lags i_rxd by 2 cycles.
- Baud counter counts 0..limit-1, then fires a sample tick and reloads to 0.
- FSM states:
  - IDLE: on rx_s==0 → START, counter=0.
  - START: tick after HALF cycles; sample rx_s. If 1 (glitch) → IDLE. If 0 → DATA, bit index=0.
  - DATA: tick every CPB cycles. Shift rx_s in LSB-first. After bit 7 → STOP (or PARITY when enabled).
  - STOP: tick after CPB cycles; sample rx_s.
    - If 1: push byte, → IDLE.
    - If 0: set o_frame_err, discard byte, → BRK.
  - BRK: wait for rx_s==1, then → IDLE. A held-low line (break) produces exactly one frame error, not repeated frames.
- Push timing:
  - Push occurs in the cycle after the stop sample.
  - o_data/o_valid reflect the new head 1 cycle after the push when the FIFO was empty.
  - Latency: falling edge of i_rxd to o_valid = 2 + HALF + 9*CPB + 1 cycles.
- FIFO:
  - Read and write pointers carry 1 extra bit for full/empty; they wrap modulo FIFO_DEPTH.
  - Pop when empty is ignored.
  - Push when full: byte dropped, o_overrun set, FIFO contents unchanged.
  - Push and pop in the same cycle when full: both take effect; no overrun; count unchanged.
  - Push and pop in the same cycle when empty: push only (o_valid was 0).
- o_data holds its value while o_valid & !i_ready; stable-while-valid rule.
- Error flags:
  - i_err_clr and a new error in the same cycle: the new error wins (flag stays 1).
  - Error flags never block reception.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP: one tick after CPB cycles.
  - Samples an even-parity bit.
  - On mismatch, the byte is discarded and o_frame_err is set, even if the stop bit is good.
  - Frame becomes 8E1; latency gains CPB cycles.
- Undefined: 8N1 only; no parity logic is synthesised.

Test Plan:
- All tests use CLK_FREQ=1_000_000, BAUD=100_000, so CPB=10 and HALF=5.
- Single byte: send 0xA5 with i_ready=1 → o_valid pulses 1 cycle with o_data=0xA5, first high 98 cycles after the rx falling edge; no errors set.
- Glitch: drive i_rxd low for 3 cycles, then high → FSM returns to IDLE; o_valid stays 0, o_frame_err stays 0; o_busy high for at most 8 cycles.
- Framing: send 0x3C with the stop bit low, then hold low 50 cycles, then high → o_frame_err=1, no push, exactly one error. A following valid 0x11 is received correctly. i_err_clr pulse → o_frame_err=0.
- Overrun: i_ready=0, send 0x01..0x05 back-to-back → FIFO holds 0x01..0x04 and o_overrun=1. Then i_ready=1 → pops 0x01,0x02,0x03,0x04 in consecutive cycles, then o_valid=0.
- Full with simultaneous pop: FIFO full; assert i_ready for 1 cycle exactly on the push cycle of 0x55 → no overrun; 0x55 ends up last in the FIFO.
- Reset mid-frame: assert wb_rst during data bit 4 of 0xFF → all outputs 0; the next frame 0x80 is received as 0x80.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver feeding a small byte FIFO.
//
// Deserialises 8N1 frames from the asynchronous rx pin. Each good byte goes
// into a FIFO that the bus bridge reads as a valid/ready byte stream. Two
// sticky error flags report framing errors and bytes dropped on a full FIFO.
//
// Optional build macro: UART_RX_PARITY_EN. When it is defined, an even-parity
// bit is expected between the data bits and the stop bit (8E1 framing). A
// parity mismatch discards the byte and raises o_frame_err.
//
// Ports:
//   wb_clk       in   system clock
//   wb_rst       in   synchronous active-high reset
//   i_rxd        in   asynchronous serial input, idle high
//   o_data[7:0]  out  byte at the FIFO head (0 while the FIFO is empty)
//   o_valid      out  FIFO non-empty
//   i_ready      in   consumer takes o_data; a pop happens on o_valid & i_ready
//   o_frame_err  out  sticky: bad stop bit (or a parity mismatch)
//   o_overrun    out  sticky: byte dropped because the FIFO was full
//   i_err_clr    in   one-cycle pulse that clears both sticky flags
//   o_busy       out  receiver FSM is not idle
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    input  logic       i_rxd,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    input  logic       i_err_clr,
    output logic       o_busy
);

    localparam int CPB   = CLK_FREQ / BAUD;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK
    } state_t;

    state_t           state_q;
    logic             sync1_q;
    logic             rx_s_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] lim_m1;
    logic             tick;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             push_q;
    logic             frame_ok;
    logic             frame_set;
`ifdef UART_RX_PARITY_EN
    logic             par_err_q;
`endif

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             empty, full, pop, wr_en, ovr_set;
    logic             frame_err_q, overrun_q;

    // Two-flop synchroniser. Both flops reset to idle-high so that the end of
    // reset never looks like a start bit.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= i_rxd;
            rx_s_q  <= sync1_q;
        end
    end

    // The start bit is sampled after half a bit time; every other sample
    // comes one full bit time after the previous one, i.e. at mid-bit.
    assign lim_m1 = (state_q == ST_START) ? CNT_W'(HALF - 1) : CNT_W'(CPB - 1);
    assign tick   = (cnt_q == lim_m1);

`ifdef UART_RX_PARITY_EN
    assign frame_ok = rx_s_q && !par_err_q;
`else
    assign frame_ok = rx_s_q;
`endif
    assign frame_set = (state_q == ST_STOP) && tick && !frame_ok;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            push_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            push_q <= 1'b0;
            cnt_q  <= tick ? '0 : cnt_q + CNT_W'(1);
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) state_q <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        // A line that is already high again was only a glitch.
                        if (rx_s_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        // Even parity: data bits plus parity bit XOR to 0.
                        par_err_q <= rx_s_q ^ (^shift_q);
                        state_q   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (frame_ok) begin
                            push_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (!rx_s_q) begin
                            state_q <= ST_BRK;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_BRK: begin
                    // Hold off until the line returns high so that a break
                    // is reported once instead of as a stream of bad frames.
                    cnt_q <= '0;
                    if (rx_s_q) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // LSB-first shift. The byte stays put until the next frame's first data
    // sample, so the push one cycle after the stop sample can read it here.
    always_ff @(posedge wb_clk) begin
        if (state_q == ST_DATA && tick) begin
            shift_q <= {rx_s_q, shift_q[7:1]};
        end
    end

    // FIFO with one extra pointer bit to tell full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop     = !empty && i_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds when the head is being taken.
    assign wr_en   = push_q && (!full || pop);
    assign ovr_set = push_q && full && !pop;

    assign wr_ptr_d = wr_en ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = pop   ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= shift_q;
        end
    end

    // Sticky flags: a new error in the clear cycle keeps the flag set.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_set | (frame_err_q & ~i_err_clr);
            overrun_q   <= ovr_set   | (overrun_q   & ~i_err_clr);
        end
    end

    assign o_valid     = !empty;
    assign o_data      = o_valid ? mem_q[rd_ptr_q[PTR_W-1:0]] : 8'h00;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = 10;
    localparam int HALF     = 5;
    localparam int DEPTH    = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Edge on which the byte lands in the FIFO, counted from the first clock
    // edge that sees the start bit low; the frame error appears one edge earlier.
    localparam int PUSH_OFS = 2 + HALF + (NB - 1) * CPB + 1;
    localparam int ERR_OFS  = PUSH_OFS - 1;

    logic       wb_clk = 1'b0;
    logic       wb_rst;
    logic       i_rxd;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overrun;
    logic       i_err_clr;
    logic       o_busy;

    uart_rx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .i_rxd      (i_rxd),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun),
        .i_err_clr  (i_err_clr),
        .o_busy     (o_busy)
    );

    always #5 wb_clk = ~wb_clk;

    int total = 0;
    int bad   = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endfunction

    // Reference model: a byte queue, two flags and a list of frame outcomes.
    typedef struct {
        int         at;
        logic [7:0] d;
        bit         good;
    } ev_t;

    int         cyc = 0;
    logic [7:0] mq[$];
    ev_t        evq[$];
    bit         m_frame = 0;
    bit         m_ovr = 0;
    bit         chk_en = 0;
    int         last_t0 = 0;

    task automatic model_step();
        bit         do_pop, was_full, has_push, new_fe, new_ov;
        logic [7:0] pd;
        ev_t        ev;
        cyc++;
        if (wb_rst) begin
            mq.delete();
            evq.delete();
            m_frame = 0;
            m_ovr   = 0;
            return;
        end
        do_pop   = i_ready && (mq.size() > 0);
        was_full = (mq.size() == DEPTH);
        has_push = 0;
        new_fe   = 0;
        new_ov   = 0;
        pd       = 8'h00;
        while (evq.size() > 0 && evq[0].at <= cyc) begin
            ev = evq.pop_front();
            if (ev.at == cyc) begin
                if (ev.good) begin
                    has_push = 1;
                    pd       = ev.d;
                end else begin
                    new_fe = 1;
                end
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (has_push) begin
            if (was_full && !do_pop) new_ov = 1;
            else mq.push_back(pd);
        end
        m_frame = new_fe ? 1'b1 : (i_err_clr ? 1'b0 : m_frame);
        m_ovr   = new_ov ? 1'b1 : (i_err_clr ? 1'b0 : m_ovr);
    endtask

    initial forever begin
        @(posedge wb_clk);
        model_step();
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge wb_clk);
        if (chk_en) begin
            check("valid", {31'd0, o_valid}, {31'd0, mq.size() > 0});
            if (mq.size() > 0) check("data", {24'd0, o_data}, {24'd0, mq[0]});
            check("frame_err", {31'd0, o_frame_err}, {31'd0, m_frame});
            check("overrun", {31'd0, o_overrun}, {31'd0, m_ovr});
        end
    end

    function automatic logic bitval(int b, logic [7:0] d, logic stop);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == NB - 1) return stop;
        return ^d;
    endfunction

    // Send one frame. rst_bit selects the frame bit during which reset is
    // pulsed (-1 for none); rdy_pulse raises i_ready only on the push edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int hold_low,
                              input bit rdy_pulse, input int rst_bit);
        int t0;
        @(negedge wb_clk);
        t0      = cyc + 1;
        last_t0 = t0;
        if (stop) evq.push_back('{at: t0 + PUSH_OFS, d: d, good: 1'b1});
        else      evq.push_back('{at: t0 + ERR_OFS, d: d, good: 1'b0});
        for (int b = 0; b < NB; b++) begin
            i_rxd = bitval(b, d, stop);
            for (int j = 0; j < CPB; j++) begin
                if (rdy_pulse) i_ready = (cyc + 1 == t0 + PUSH_OFS);
                if (b == rst_bit) begin
                    if (j == 2) check("busy_mid_frame", {31'd0, o_busy}, 32'd1);
                    if (j == 3) wb_rst = 1'b1;
                    if (j == 4) begin
                        check("rst_valid", {31'd0, o_valid}, 32'd0);
                        check("rst_data", {24'd0, o_data}, 32'd0);
                        check("rst_busy", {31'd0, o_busy}, 32'd0);
                        check("rst_flags", {30'd0, o_frame_err, o_overrun}, 32'd0);
                    end
                    if (j == 5) wb_rst = 1'b0;
                end
                @(negedge wb_clk);
            end
        end
        if (hold_low > 0) begin
            repeat (hold_low) @(negedge wb_clk);
        end
        i_rxd = 1'b1;
    endtask

    // Wait (bounded) for o_valid, report latency and head byte, then check
    // that the byte was taken on the next edge.
    task automatic expect_byte(input string nm, input logic [7:0] d, input bit chk_lat);
        int  lat;
        bit  seen;
        seen = 0;
        lat  = -1;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge wb_clk);
            if (o_valid) begin
                seen = 1;
                lat  = cyc - last_t0;
                check({nm, "_data"}, {24'd0, o_data}, {24'd0, d});
            end
        end
        check({nm, "_seen"}, {31'd0, seen}, 32'd1);
        if (chk_lat) check({nm, "_latency"}, lat, PUSH_OFS);
        @(negedge wb_clk);
        check({nm, "_pulse_1cyc"}, {31'd0, o_valid}, 32'd0);
    endtask

    initial begin
        int busy_cnt;
        i_rxd     = 1'b1;
        i_ready   = 1'b0;
        wb_rst    = 1'b1;
        i_err_clr = 1'b0;
        repeat (3) @(negedge wb_clk);
        check("reset_valid", {31'd0, o_valid}, 32'd0);
        check("reset_data", {24'd0, o_data}, 32'd0);
        check("reset_frame_err", {31'd0, o_frame_err}, 32'd0);
        check("reset_overrun", {31'd0, o_overrun}, 32'd0);
        check("reset_busy", {31'd0, o_busy}, 32'd0);
        wb_rst = 1'b0;
        chk_en = 1;
        repeat (5) @(negedge wb_clk);

        // Single byte, consumer always ready.
        i_ready = 1'b1;
        fork
            send_frame(8'hA5, 1'b1, 0, 1'b0, -1);
            expect_byte("single", 8'hA5, 1'b1);
        join
        check("single_no_err", {30'd0, o_frame_err, o_overrun}, 32'd0);
        repeat (5) @(negedge wb_clk);

        // Short low glitch must not start a frame.
        i_rxd    = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            if (k == 3) i_rxd = 1'b1;
            @(negedge wb_clk);
            if (o_busy) busy_cnt++;
        end
        check("glitch_busy_1to8", {31'd0, busy_cnt >= 1 && busy_cnt <= 8}, 32'd1);
        check("glitch_idle", {31'd0, o_busy}, 32'd0);
        check("glitch_no_err", {31'd0, o_frame_err}, 32'd0);

        // Bad stop bit followed by a long break.
        send_frame(8'h3C, 1'b0, 50, 1'b0, -1);
        @(negedge wb_clk);
        check("frame_err_set", {31'd0, o_frame_err}, 32'd1);
        check("frame_no_push", {31'd0, o_valid}, 32'd0);
        i_err_clr = 1'b1;
        @(negedge wb_clk);
        i_err_clr = 1'b0;
        check("frame_err_cleared", {31'd0, o_frame_err}, 32'd0);
        repeat (60) @(negedge wb_clk);
        check("frame_err_once", {31'd0, o_frame_err}, 32'd0);
        fork
            send_frame(8'h11, 1'b1, 0, 1'b0, -1);
            expect_byte("after_break", 8'h11, 1'b1);
        join
        check("after_break_no_err", {31'd0, o_frame_err}, 32'd0);

        // Overrun: five bytes into a four-entry FIFO with no consumer.
        i_ready = 1'b0;
        for (int n = 1; n <= 5; n++) send_frame(8'(n), 1'b1, 0, 1'b0, -1);
        @(negedge wb_clk);
        check("overrun_set", {31'd0, o_overrun}, 32'd1);
        i_ready = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            check("overrun_drain", {24'd0, o_data}, n);
            @(negedge wb_clk);
        end
        check("overrun_drained", {31'd0, o_valid}, 32'd0);

        // Full FIFO with a pop on exactly the push edge.
        i_ready   = 1'b0;
        i_err_clr = 1'b1;
        @(negedge wb_clk);
        i_err_clr = 1'b0;
        check("overrun_cleared", {31'd0, o_overrun}, 32'd0);
        for (int n = 0; n < 4; n++) send_frame(8'h21 + 8'(n), 1'b1, 0, 1'b0, -1);
        send_frame(8'h55, 1'b1, 0, 1'b1, -1);
        i_ready = 1'b0;
        @(negedge wb_clk);
        check("fullpop_no_overrun", {31'd0, o_overrun}, 32'd0);
        i_ready = 1'b1;
        check("fullpop_head0", {24'd0, o_data}, 32'h22);
        @(negedge wb_clk);
        check("fullpop_head1", {24'd0, o_data}, 32'h23);
        @(negedge wb_clk);
        check("fullpop_head2", {24'd0, o_data}, 32'h24);
        @(negedge wb_clk);
        check("fullpop_last", {24'd0, o_data}, 32'h55);
        @(negedge wb_clk);
        check("fullpop_empty", {31'd0, o_valid}, 32'd0);

        // Reset in data bit 4 of 0xFF with a byte already queued.
        i_ready = 1'b0;
        send_frame(8'h77, 1'b1, 0, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 0, 1'b0, 5);
        repeat (5) @(negedge wb_clk);
        check("post_reset_empty", {31'd0, o_valid}, 32'd0);
        i_ready = 1'b1;
        fork
            send_frame(8'h80, 1'b1, 0, 1'b0, -1);
            expect_byte("post_reset", 8'h80, 1'b1);
        join
        repeat (10) @(negedge wb_clk);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got still running, want finished");
        $fatal(1, "timeout");
    end

endmodule
